// File: rtl/vid_tpg_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vid_tpg_gen: GB-style raster timing and RGB555 test-pattern source     |
// |              with frame-buffer line addressing and write strobes.      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module vid_tpg_gen #(
  parameter int          H_TOTAL   = 1824,
  parameter int          V_TOTAL   = 155,
  parameter int          PIX_DIV   = 4,
  parameter int          H_PIXELS  = 160,
  parameter int          V_LINES   = 144,
  parameter int          HS_END    = 1006,
  parameter int          VS_LINE   = 153,
  parameter logic [22:0] FB_BASE   = 23'h010000,
  parameter int          FB_STRIDE = 320
) (
  input  logic        hclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  mode,
  input  logic [14:0] solid_color,
  output logic [14:0] color_pixel,
  output logic        vs,
  output logic        hs,
  output logic        valid,
  output logic        hGBNewLine,
  output logic [22:0] hGBAddress,
  output logic        hGBWrite,
  output logic        frame_start
);

  localparam logic [11:0] c_x_last  = 12'(H_TOTAL - 1);
  localparam logic [11:0] c_y_last  = 12'(V_TOTAL - 1);
  localparam logic [11:0] c_h_act   = 12'(H_PIXELS * PIX_DIV);
  localparam logic [11:0] c_v_lines = 12'(V_LINES);
  localparam logic [11:0] c_hs_end  = 12'(HS_END);
  localparam logic [11:0] c_vs_line = 12'(VS_LINE);
  localparam int          c_ph_w    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(PIX_DIV - 1);
  localparam logic [7:0]  c_bar_w   = 8'(H_PIXELS / 8);
  localparam logic [22:0] c_stride  = 23'(FB_STRIDE);

  logic [11:0]       r_x;
  logic [11:0]       r_y;
  logic [c_ph_w-1:0] r_ph;
  logic [7:0]        r_pix_x;
  logic [7:0]        r_pix_y;
  logic [1:0]        r_fcnt;
  logic [2:0]        r_mode;
  logic [14:0]       r_solid;
  logic [14:0]       r_color;
  logic              r_valid;
  logic              r_hs;
  logic              r_vs;
  logic              r_nl;
  logic [22:0]       r_addr;
  logic              r_wr;
  logic              r_fs;

  logic              w_x_wrap;
  logic              w_y_wrap;
  logic              w_active_line;
  logic              w_strobe;
  logic [7:0]        w_bar;
  logic [4:0]        w_grey;
  logic [14:0]       w_pattern;

  assign w_x_wrap      = (r_x == c_x_last);
  assign w_y_wrap      = (r_y == c_y_last);
  assign w_active_line = (r_y < c_v_lines);
  // r_ph tracks x mod PIX_DIV, so the strobe lands on the last clock of each pixel.
  assign w_strobe      = w_active_line && (r_x < c_h_act) && (r_ph == c_ph_last);

  always_comb begin
    w_bar     = r_pix_x / c_bar_w;
    w_grey    = r_pix_x[7:3];
    w_pattern = 15'h0000;
    case (r_mode)
      3'd0: begin
        case (r_fcnt)
          2'd0:    w_pattern = {10'd0, r_y[4:0]};
          2'd1:    w_pattern = {5'd0, r_y[4:0], 5'd0};
          default: w_pattern = {r_y[4:0], 10'd0};
        endcase
      end
      3'd1: begin
        case (w_bar)
          8'd0:    w_pattern = 15'h7FFF;
          8'd1:    w_pattern = 15'h7FE0;
          8'd2:    w_pattern = 15'h03FF;
          8'd3:    w_pattern = 15'h03E0;
          8'd4:    w_pattern = 15'h7C1F;
          8'd5:    w_pattern = 15'h7C00;
          8'd6:    w_pattern = 15'h001F;
          default: w_pattern = 15'h0000;
        endcase
      end
      3'd2:    w_pattern = (r_pix_x[3] ^ r_pix_y[3]) ? 15'h7FFF : 15'h0000;
      3'd3:    w_pattern = {w_grey, w_grey, w_grey};
      3'd4:    w_pattern = r_solid;
      default: w_pattern = 15'h0000;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_ph    <= '0;
      r_pix_x <= '0;
      r_pix_y <= '0;
      r_fcnt  <= '0;
      r_mode  <= '0;
      r_solid <= '0;
      r_color <= '0;
      r_valid <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_nl    <= 1'b0;
      r_addr  <= FB_BASE;
      r_wr    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_nl    <= 1'b0;
      r_fs    <= 1'b0;
      if (enable) begin
        r_hs    <= (r_x < c_hs_end);
        r_vs    <= (r_y == c_vs_line);
        r_valid <= w_strobe;
        r_wr    <= r_valid;
        r_nl    <= (r_x == c_h_act) && w_active_line;
        r_fs    <= w_x_wrap && w_y_wrap;
        if (w_strobe) begin
          r_color <= w_pattern;
        end
        if (w_x_wrap) begin
          r_x     <= '0;
          r_ph    <= '0;
          r_pix_x <= '0;
          r_addr  <= r_addr + c_stride;
          if (w_active_line) begin
            r_pix_y <= r_pix_y + 8'd1;
          end
          if (w_y_wrap) begin
            // Frame wrap: base reload wins over the stride add above.
            r_y     <= '0;
            r_pix_y <= '0;
            r_fcnt  <= (r_fcnt == 2'd2) ? 2'd0 : r_fcnt + 2'd1;
            r_mode  <= mode;
            r_solid <= solid_color;
            r_addr  <= FB_BASE;
          end else begin
            r_y <= r_y + 12'd1;
          end
        end else begin
          r_x  <= r_x + 12'd1;
          r_ph <= (r_ph == c_ph_last) ? '0 : r_ph + 1'b1;
          if (w_strobe) begin
            r_pix_x <= r_pix_x + 8'd1;
          end
        end
      end
    end
  end

  assign color_pixel = r_color;
  assign vs          = r_vs;
  assign hs          = r_hs;
  assign valid       = r_valid;
  assign hGBNewLine  = r_nl;
  assign hGBAddress  = r_addr;
  assign hGBWrite    = r_wr;
  assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vid_tpg_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_vid_tpg_gen: reduced-raster bench for vid_tpg_gen with a per-cycle  |
// |                 reference model and directed literal checks.           |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_vid_tpg_gen;

  localparam int          TB_H_TOTAL  = 200;
  localparam int          TB_V_TOTAL  = 20;
  localparam int          TB_PIX_DIV  = 4;
  localparam int          TB_H_PIXELS = 40;
  localparam int          TB_V_LINES  = 12;
  localparam int          TB_HS_END   = 110;
  localparam int          TB_VS_LINE  = 15;
  localparam logic [22:0] TB_FB_BASE  = 23'h7FFE00;
  localparam int          TB_STRIDE   = 320;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [2:0]  mode;
  logic [14:0] solid_color;
  logic [14:0] color_pixel;
  logic        vs, hs, valid, hGBNewLine, hGBWrite, frame_start;
  logic [22:0] hGBAddress;

  vid_tpg_gen #(
    .H_TOTAL(TB_H_TOTAL), .V_TOTAL(TB_V_TOTAL), .PIX_DIV(TB_PIX_DIV),
    .H_PIXELS(TB_H_PIXELS), .V_LINES(TB_V_LINES), .HS_END(TB_HS_END),
    .VS_LINE(TB_VS_LINE), .FB_BASE(TB_FB_BASE), .FB_STRIDE(TB_STRIDE)
  ) dut (
    .hclk(clk), .reset(reset), .enable(enable), .mode(mode),
    .solid_color(solid_color), .color_pixel(color_pixel), .vs(vs), .hs(hs),
    .valid(valid), .hGBNewLine(hGBNewLine), .hGBAddress(hGBAddress),
    .hGBWrite(hGBWrite), .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic bit is_strobe(int x, int y);
    return (y < TB_V_LINES) && (x < TB_H_PIXELS * TB_PIX_DIV) &&
           ((x % TB_PIX_DIV) == TB_PIX_DIV - 1);
  endfunction

  function automatic logic [14:0] exp_pixel(int px, int py, int f, logic [2:0] m, logic [14:0] s);
    int g;
    case (m)
      3'd0: return 15'((py % 32) << (5 * f));
      3'd1: begin
        case (px / (TB_H_PIXELS / 8))
          0:       return 15'h7FFF;
          1:       return 15'h7FE0;
          2:       return 15'h03FF;
          3:       return 15'h03E0;
          4:       return 15'h7C1F;
          5:       return 15'h7C00;
          6:       return 15'h001F;
          default: return 15'h0000;
        endcase
      end
      3'd2: return ((((px / 8) + (py / 8)) % 2) == 1) ? 15'h7FFF : 15'h0000;
      3'd3: begin
        g = px / 8;
        return 15'(g * 1057);
      end
      3'd4:    return s;
      default: return 15'h0000;
    endcase
  endfunction

  function automatic logic [22:0] exp_addr(int line);
    longint a;
    a = longint'(TB_FB_BASE) + longint'(line) * TB_STRIDE;
    return a[22:0];
  endfunction

  int          mx, my, mf;
  logic [2:0]  mm;
  logic [14:0] ms;
  logic        e_hs, e_vs, e_valid, e_wr, e_nl, e_fs;
  logic [14:0] e_col;

  always @(posedge clk) begin
    if (reset) begin
      mx <= 0; my <= 0; mf <= 0; mm <= '0; ms <= '0;
      e_hs <= 0; e_vs <= 0; e_valid <= 0; e_wr <= 0; e_nl <= 0; e_fs <= 0;
      e_col <= '0;
    end else if (enable) begin
      e_hs    <= (mx < TB_HS_END);
      e_vs    <= (my == TB_VS_LINE);
      e_valid <= is_strobe(mx, my);
      e_wr    <= e_valid;
      e_nl    <= (mx == TB_H_PIXELS * TB_PIX_DIV) && (my < TB_V_LINES);
      e_fs    <= (mx == TB_H_TOTAL - 1) && (my == TB_V_TOTAL - 1);
      if (is_strobe(mx, my)) e_col <= exp_pixel(mx / TB_PIX_DIV, my, mf, mm, ms);
      if (mx == TB_H_TOTAL - 1) begin
        mx <= 0;
        if (my == TB_V_TOTAL - 1) begin
          my <= 0; mf <= (mf + 1) % 3; mm <= mode; ms <= solid_color;
        end else begin
          my <= my + 1;
        end
      end else begin
        mx <= mx + 1;
      end
    end else begin
      e_valid <= 0; e_wr <= 0; e_nl <= 0; e_fs <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(valid), 32'(e_valid));
      chk("hGBWrite", 32'(hGBWrite), 32'(e_wr));
      chk("hGBNewLine", 32'(hGBNewLine), 32'(e_nl));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("hs", 32'(hs), 32'(e_hs));
      chk("vs", 32'(vs), 32'(e_vs));
      chk("color_pixel", 32'(color_pixel), 32'(e_col));
      chk("hGBAddress", 32'(hGBAddress), 32'(exp_addr(my)));
    end
  end

  // ---------------- pulse counters ----------------
  int cyc = 0, cnt_valid = 0, cnt_nl = 0, cnt_vs = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid)      cnt_valid <= cnt_valid + 1;
    if (hGBNewLine) cnt_nl    <= cnt_nl + 1;
    if (vs)         cnt_vs    <= cnt_vs + 1;
  end

  // ---------------- directed helpers ----------------
  logic [14:0] cap [TB_H_PIXELS];

  task automatic wait_fs();
    int t = 0;
    do begin @(negedge clk); t++; end while (!frame_start && t < 5000);
    chk("wait_frame_start", 32'(frame_start), 32'd1);
  endtask

  task automatic wait_nl();
    int t = 0;
    do begin @(negedge clk); t++; end while (!hGBNewLine && t < 1000);
    chk("wait_newline", 32'(hGBNewLine), 32'd1);
  endtask

  task automatic capture_line();
    int n = 0, t = 0;
    while (n < TB_H_PIXELS && t < 1000) begin
      @(negedge clk);
      t++;
      if (valid) begin cap[n] = color_pixel; n++; end
    end
    chk("capture_count", 32'(n), 32'(TB_H_PIXELS));
  endtask

  task automatic first_valid_latency(string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!valid && n < 50);
    chk(nm, 32'(n), 32'd4);
  endtask

  task automatic check_reset_state(string nm);
    chk({nm, "_valid"}, 32'(valid), 32'd0);
    chk({nm, "_hs"}, 32'(hs), 32'd0);
    chk({nm, "_vs"}, 32'(vs), 32'd0);
    chk({nm, "_color"}, 32'(color_pixel), 32'd0);
    chk({nm, "_nl"}, 32'(hGBNewLine), 32'd0);
    chk({nm, "_wr"}, 32'(hGBWrite), 32'd0);
    chk({nm, "_fs"}, 32'(frame_start), 32'd0);
    chk({nm, "_addr"}, 32'(hGBAddress), 32'h007FFE00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, v0, n0, s0, vp, bad;
    reset = 1'b1; enable = 1'b1; mode = 3'd0; solid_color = 15'h0000;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    chk_en = 1'b1;
    reset  = 1'b0;
    first_valid_latency("first_valid_latency");

    // Full-frame pulse counts and frame period.
    wait_fs();
    chk("addr_frame_start", 32'(hGBAddress), 32'h007FFE00);
    c0 = cyc; v0 = cnt_valid; n0 = cnt_nl; s0 = cnt_vs;
    wait_fs();
    chk("frame_period", 32'(cyc - c0), 32'd4000);
    chk("valid_per_frame", 32'(cnt_valid - v0), 32'd480);
    chk("newline_per_frame", 32'(cnt_nl - n0), 32'd12);
    chk("vs_high_clocks", 32'(cnt_vs - s0), 32'd200);
    repeat (2 * TB_H_TOTAL) @(negedge clk);
    chk("addr_line2_wrap", 32'(hGBAddress), 32'h00000080);

    // Colour bars, then a mid-frame mode change that must not take effect yet.
    mode = 3'd1;
    wait_fs();
    capture_line();
    chk("bars_px0", 32'(cap[0]), 32'h7FFF);
    chk("bars_px4", 32'(cap[4]), 32'h7FFF);
    chk("bars_px5", 32'(cap[5]), 32'h7FE0);
    chk("bars_px35", 32'(cap[35]), 32'h0000);
    mode = 3'd2;
    capture_line();
    chk("bars_after_midframe_change", 32'(cap[5]), 32'h7FE0);

    // Checkerboard.
    wait_fs();
    capture_line();
    chk("checker_8_0", 32'(cap[8]), 32'h7FFF);
    chk("checker_0_0", 32'(cap[0]), 32'h0000);
    repeat (8) capture_line();
    chk("checker_8_8", 32'(cap[8]), 32'h0000);
    chk("checker_0_8", 32'(cap[0]), 32'h7FFF);

    // Solid colour.
    mode = 3'd4; solid_color = 15'h1234;
    wait_fs();
    capture_line();
    bad = 0;
    for (int i = 0; i < TB_H_PIXELS; i++) if (cap[i] !== 15'h1234) bad++;
    chk("solid_line_mismatches", 32'(bad), 32'd0);

    // Pause mid-line: no strobes while paused, line still yields every pixel.
    wait_nl();
    v0 = cnt_valid;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    vp = 0;
    repeat (100) begin @(negedge clk); if (valid || hGBWrite) vp++; end
    chk("strobes_during_pause", 32'(vp), 32'd0);
    enable = 1'b1;
    wait_nl();
    chk("valid_in_paused_line", 32'(cnt_valid - v0), 32'(TB_H_PIXELS));

    // Mid-frame reset aborts the frame.
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    reset = 1'b0;
    first_valid_latency("valid_latency_after_reset");
    wait_fs();
    capture_line();
    chk("solid_after_reset_frame", 32'(cap[0]), 32'h1234);
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vid_tpg_gen.md
# vid_tpg_gen

Parametrised video test-pattern generator for the GB-LCD capture path. It produces GB-style raster timing (`vs`, `hs`, `valid`) with decimated pixel strobes, and drives frame-buffer line addressing and write strobes (`hGBNewLine`, `hGBAddress`, `hGBWrite`). It selects among several RGB555 patterns at run time, so scaler, framebuffer and display paths can be brought up without a live GB core.

## Interface
Parameters:
- `H_TOTAL`, 1824: clocks per line.
- `V_TOTAL`, 155: lines per frame.
- `PIX_DIV`, 4: clocks per active pixel.
- `H_PIXELS`, 160: active pixels per line. Must be a multiple of 8.
- `V_LINES`, 144: active lines.
- `HS_END`, 1006: `hs` is high for x < HS_END.
- `VS_LINE`, 153: line on which `vs` is high.
- `FB_BASE`, 23'h010000: frame-buffer base address.
- `FB_STRIDE`, 320: address increment per line.

Ports:
- `hclk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run/pause.
- `mode`  in  3  pattern select. Latched at frame start.
- `solid_color`  in  15  colour for mode 4. Latched at frame start.
- `color_pixel`  out  15  RGB555 as {R[14:10],G[9:5],B[4:0]}.
- `vs`  out  1  vertical sync.
- `hs`  out  1  horizontal sync.
- `valid`  out  1  pixel strobe.
- `hGBNewLine`  out  1  one-clock line-start pulse to the framebuffer.
- `hGBAddress`  out  23  current line base address.
- `hGBWrite`  out  1  framebuffer write strobe.
- `frame_start`  out  1  one-clock pulse on frame wrap.

## Operation
Counters:
- x runs 0..H_TOTAL-1 and y runs 0..V_TOTAL-1. Both are 12 bits.
- x wraps to 0 at H_TOTAL-1. On that wrap, y increments, or wraps to 0 at V_TOTAL-1.
- On the y wrap (frame wrap):
  - pulse `frame_start`;
  - latch `mode` and `solid_color`;
  - advance fcnt mod 3;
  - clear pix_y.

Pixel strobes and pixel coordinates:
- Pixel strobe condition: y < V_LINES and x = k·PIX_DIV + PIX_DIV-1 for k in 0..H_PIXELS-1.
- This gives exactly H_PIXELS strobes per active line.
- pix_x (8 bit) increments after each strobe and clears at line wrap.
- pix_y (8 bit) increments at the wrap of each active line.

Pattern for the strobed pixel, by latched mode:
- 0, legacy ramp: channel B/G/R for fcnt 0/1/2 gets y[4:0]; the other channels are 0.
- 1, colour bars: bar = pix_x / (H_PIXELS/8). Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black. Each channel is 5'h1F or 0.
- 2, checkerboard: 8×8 cells. 15'h7FFF if pix_x[3]^pix_y[3], else 0.
- 3, grey gradient: all three channels = pix_x[7:3].
- 4, solid: latched `solid_color`.
- 5–7: 0.

Framebuffer addressing:
- `hGBAddress` adds FB_STRIDE at each line wrap.
- At frame wrap, `hGBAddress` loads FB_BASE. The frame-wrap load takes priority over the stride add.

Pause (`enable` = 0):
- x, y, pix and fcnt hold.
- `valid`, `hGBWrite`, `hGBNewLine` and `frame_start` are forced 0.
- `hs`, `vs` and `color_pixel` hold.
- When `enable` returns to 1, counting resumes from the held position.

Reset:
- Sets x=y=pix_x=pix_y=fcnt=0, latched mode=0, latched colour=0.
- A reset asserted mid-frame aborts that frame immediately.
- The next frame starts at x=0, y=0 with mode 0 until the first frame wrap.

## Timing
Reset values:
- `hGBAddress` = FB_BASE.
- All other outputs = 0.

Output latencies:
- `hs` and `vs` are registered from x and y: 1-clock latency.
- `valid` and `color_pixel` are asserted together, 1 clock after the strobe count.
- `hGBWrite` is `valid` delayed 1 clock. It pairs with the following `hGBAddress`/pixel-index consumer.
- `hGBNewLine` pulses 1 clock after x == H_PIXELS·PIX_DIV, only when y < V_LINES.
- `frame_start` is high the clock after x=H_TOTAL-1, y=V_TOTAL-1.
- `hGBAddress` is valid for the whole line. It updates in the clock after the line wrap.

Other rules:
- Latched mode and colour change only at frame wrap. A `mode` change mid-frame never affects the current frame.
- Address arithmetic is modulo 2^23.

## Test plan
- Reset then run one frame with defaults, mode 0 → 282720 clocks between `frame_start` pulses, 23040 `valid` pulses, 144 `hGBNewLine` pulses, `vs` high for 1824 clocks.
- Line timing, defaults → first `valid` 4 clocks after x=0 (at x=3, plus 1 clock of registration), consecutive `valid` 4 clocks apart; `hs` high for 1006 clocks of each 1824; `hGBWrite` trails each `valid` by 1.
- Address check, defaults → `hGBAddress` = 0x010000 on line 0, 0x1B2C0 on line 143, back to 0x010000 after `frame_start`.
- Mode 1, `mode` driven before a frame wrap → pixels 0–19 = 7FFF, 20–39 = 7FE0, 140–159 = 0000; a mid-frame `mode` change has no effect until the next `frame_start`.
- Mode 2 and mode 4 with `solid_color`=15'h1234 → checker pixel (8,0) = 7FFF, (8,8) = 0000; solid frame all 1234.
- Pulse `enable` low for 100 clocks mid-line, then assert `reset` mid-frame → no strobes during the pause and the line resumes intact; after reset, all outputs are 0, `hGBAddress`=0x010000, and the first `valid` appears 4 clocks after release.
